// File: rtl/modexp_io_buffer.sv
// modexp_io_buffer: word-serial operand/result buffer between the ModExp host loader and the Montgomery datapath.
module modexp_io_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 64,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] m_in,
    input  logic [DATA_WIDTH-1:0] e_in,
    input  logic [DATA_WIDTH-1:0] n_in,
    input  logic [DATA_WIDTH-1:0] r_in,
    input  logic [DATA_WIDTH-1:0] t_in,
    output logic                  in_ready,
    output logic                  load_done,
    input  logic [AW-1:0]         op_addr,
    output logic [DATA_WIDTH-1:0] op_m,
    output logic [DATA_WIDTH-1:0] op_e,
    output logic [DATA_WIDTH-1:0] op_n,
    output logic [DATA_WIDTH-1:0] op_r,
    output logic [DATA_WIDTH-1:0] op_t,
    input  logic                  res_we,
    input  logic [AW-1:0]         res_addr,
    input  logic [DATA_WIDTH-1:0] res_wdata,
    input  logic                  core_done,
    input  logic                  get_result,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    output logic                  res_last,
    output logic [2:0]            state
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, READY = 3'd2, DONE = 3'd3, UNLOAD = 3'd4} state_t;
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] LAST = (AW+1)'(WORDS - 1);
    localparam logic [AW:0] STOP = (AW+1)'(WORDS);
    state_t st;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] m_mem [WORDS];
    logic [DATA_WIDTH-1:0] e_mem [WORDS];
    logic [DATA_WIDTH-1:0] n_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] t_mem [WORDS];
    logic [DATA_WIDTH-1:0] res_mem [WORDS];
    logic accept, res_commit;
    logic [AW-1:0] waddr;
    assign state      = st;
    assign accept     = reset && in_valid && (st == IDLE || st == LOAD);
    assign res_commit = reset && res_we && st == READY;
    assign waddr      = st == IDLE ? '0 : wr_ptr[AW-1:0];
    // Storage has no reset: contents survive aborts and stale reads are allowed.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_mem[waddr] <= m_in;
            e_mem[waddr] <= e_in;
            n_mem[waddr] <= n_in;
            r_mem[waddr] <= r_in;
            t_mem[waddr] <= t_in;
        end
        if (res_commit) res_mem[res_addr] <= res_wdata;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            load_done <= 1'b0;
            op_m      <= '0;
            op_e      <= '0;
            op_n      <= '0;
            op_r      <= '0;
            op_t      <= '0;
            res_out   <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            op_m      <= m_mem[op_addr];
            op_e      <= e_mem[op_addr];
            op_n      <= n_mem[op_addr];
            op_r      <= r_mem[op_addr];
            op_t      <= t_mem[op_addr];
            load_done <= 1'b0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            case (st)
                IDLE: if (in_valid) begin
                    wr_ptr <= ONE;
                    if (WORDS == 1) begin
                        st        <= READY;
                        in_ready  <= 1'b0;
                        load_done <= 1'b1;
                    end else st <= LOAD;
                end
                LOAD: if (in_valid) begin
                    wr_ptr <= wr_ptr + ONE;
                    if (wr_ptr == LAST) begin
                        st        <= READY;
                        in_ready  <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                READY: if (core_done) st <= DONE;
                DONE: if (get_result) begin
                    rd_ptr <= '0;
                    st     <= UNLOAD;
                end
                // The extra pointer bit lets the cycle after the last word be told apart.
                UNLOAD: if (rd_ptr == STOP) begin
                    st       <= IDLE;
                    in_ready <= 1'b1;
                end else begin
                    res_out   <= res_mem[rd_ptr[AW-1:0]];
                    res_valid <= 1'b1;
                    res_last  <= rd_ptr == LAST;
                    rd_ptr    <= rd_ptr + ONE;
                end
                default: begin
                    st       <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_io_buffer.sv
// tb_modexp_io_buffer: randomized load/compute/unload transactions against an array-based model of the buffer.
module tb_modexp_io_buffer;
    localparam int DW = 64;
    localparam int W  = 64;
    localparam int AW = 6;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic [DW-1:0] m_in = '0, e_in = '0, n_in = '0, r_in = '0, t_in = '0;
    logic in_ready, load_done;
    logic [AW-1:0] op_addr = '0;
    logic [DW-1:0] op_m, op_e, op_n, op_r, op_t;
    logic res_we = 1'b0;
    logic [AW-1:0] res_addr = '0;
    logic [DW-1:0] res_wdata = '0;
    logic core_done = 1'b0, get_result = 1'b0;
    logic [DW-1:0] res_out;
    logic res_valid, res_last;
    logic [2:0] state;
    logic [DW-1:0] mm [W], em [W], nm [W], rm [W], tm [W], res_m [W];
    int errors = 0;
    int checks = 0;

    modexp_io_buffer #(.DATA_WIDTH(DW), .WORDS(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .m_in(m_in), .e_in(e_in), .n_in(n_in), .r_in(r_in), .t_in(t_in),
        .in_ready(in_ready), .load_done(load_done), .op_addr(op_addr),
        .op_m(op_m), .op_e(op_e), .op_n(op_n), .op_r(op_r), .op_t(op_t),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
        .core_done(core_done), .get_result(get_result),
        .res_out(res_out), .res_valid(res_valid), .res_last(res_last), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd;
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_aborted(input string tag);
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_ldone"}, 64'(load_done), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    // mode 0: sparse basic pattern, 1: gapped i+1 pattern, 2: random words
    task automatic load(input int mode, input int abort_at, input bit noise);
        logic [DW-1:0] w [5];
        for (int i = 0; i < W; i++) begin
            if (mode == 1 && i > 0) begin
                in_valid = 1'b0;
                m_in = rnd();
                step();
                check("gap_ldone", 64'(load_done), 64'd0);
            end
            for (int k = 0; k < 5; k++)
                w[k] = mode == 0 ? (i == 0 ? (k == 0 ? 64'd8 : k == 1 ? 64'd13 : k == 2 ? 64'd77 : 64'd0) : 64'd0)
                     : mode == 1 ? (k == 0 ? 64'(i + 1) : rnd()) : rnd();
            {m_in, e_in, n_in, r_in, t_in} = {w[0], w[1], w[2], w[3], w[4]};
            in_valid = 1'b1;
            res_we = noise;
            res_addr = AW'($urandom_range(0, W - 1));
            res_wdata = rnd();
            if (i == abort_at) reset = 1'b0;
            step();
            if (i == abort_at) begin
                check_aborted("load_abort");
                reset = 1'b1;
                in_valid = 1'b0;
                res_we = 1'b0;
                return;
            end
            {mm[i], em[i], nm[i], rm[i], tm[i]} = {w[0], w[1], w[2], w[3], w[4]};
            if (i < W - 1) begin
                check("load_ldone", 64'(load_done), 64'd0);
                check("load_ready", 64'(in_ready), 64'd1);
                check("load_state", 64'(state), 64'd1);
            end else begin
                check("last_ldone", 64'(load_done), 64'd1);
                check("last_ready", 64'(in_ready), 64'd0);
                check("last_state", 64'(state), 64'd2);
            end
        end
        in_valid = 1'b0;
        res_we = 1'b0;
        step();
        check("ldone_pulse", 64'(load_done), 64'd0);
        check("ready_state", 64'(state), 64'd2);
    endtask

    task automatic read(input int a);
        op_addr = AW'(a);
        step();
        check("op_m", op_m, mm[a]);
        check("op_e", op_e, em[a]);
        check("op_n", op_n, nm[a]);
        check("op_r", op_r, rm[a]);
        check("op_t", op_t, tm[a]);
    endtask

    // Writes every address (3*addr) or a random subset (random data) while in_valid noise is offered.
    task automatic compute(input bit all, input bit simul);
        for (int a = 0; a < W; a++) begin
            in_valid = 1'b1;
            m_in = rnd();
            res_we = all || $urandom_range(0, 1) == 1;
            res_addr = AW'(a);
            res_wdata = all ? 64'(a * 3) : rnd();
            if (res_we) res_m[a] = res_wdata;
            step();
        end
        in_valid = 1'b0;
        res_we = simul;
        res_addr = AW'(W - 1);
        res_wdata = 64'hAB;
        core_done = 1'b1;
        step();
        if (simul) res_m[W-1] = 64'hAB;
        core_done = 1'b0;
        check("done_state", 64'(state), 64'd3);
        check("done_ready", 64'(in_ready), 64'd0);
        res_we = 1'b1;
        res_addr = AW'($urandom_range(0, W - 1));
        res_wdata = rnd();
        in_valid = 1'b1;
        step();
        res_we = 1'b0;
        in_valid = 1'b0;
        check("done_hold", 64'(state), 64'd3);
        for (int k = 0; k < 3; k++) read($urandom_range(0, W - 1));
    endtask

    task automatic unload(input int abort_at);
        get_result = 1'b1;
        step();
        get_result = 1'b0;
        check("unl_state", 64'(state), 64'd4);
        check("unl_valid0", 64'(res_valid), 64'd0);
        for (int i = 0; i < W; i++) begin
            step();
            check("res_valid", 64'(res_valid), 64'd1);
            check("res_out", res_out, res_m[i]);
            check("res_last", 64'(res_last), 64'(i == W - 1));
            if (i == abort_at) begin
                reset = 1'b0;
                step();
                check_aborted("unl_abort");
                reset = 1'b1;
                return;
            end
        end
        step();
        check("end_valid", 64'(res_valid), 64'd0);
        check("end_last", 64'(res_last), 64'd0);
        check("end_state", 64'(state), 64'd0);
        check("end_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        step();
        step();
        check("rst_state", 64'(state), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_ldone", 64'(load_done), 64'd0);
        check("rst_op_m", op_m, 64'd0);
        check("rst_res_out", res_out, 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_last", 64'(res_last), 64'd0);
        reset = 1'b1;
        get_result = 1'b1;
        step();
        get_result = 1'b0;
        check("idle_get_state", 64'(state), 64'd0);
        check("idle_get_valid", 64'(res_valid), 64'd0);
        load(0, -1, 1'b0);
        read(0);
        read(5);
        compute(1'b1, 1'b0);
        unload(-1);
        load(1, -1, 1'b1);
        read(63);
        check("gap_m63", op_m, 64'd64);
        compute(1'b0, 1'b1);
        unload(-1);
        load(2, 30, 1'b0);
        load(2, -1, 1'b0);
        for (int k = 0; k < 6; k++) read($urandom_range(0, W - 1));
        compute(1'b0, 1'b0);
        unload(10);
        load(2, -1, 1'b0);
        compute(1'b1, 1'b1);
        unload(-1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
